// File: rtl/id_stat_pkg.sv
// rtl/id_stat_pkg.sv - shared state encoding and default widths for id_stat
package id_stat_pkg;

  // Default width of the completed-identifier counter
  localparam int CNT_W_DEF = 8;
  // Default width of the run-length / length registers
  localparam int LEN_W_DEF = 6;

  // IDLE: no token in progress, RUN: token in progress
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/id_stat_if.sv
// rtl/id_stat_if.sv - sample stream and statistics bus for id_stat
interface id_stat_if
  import id_stat_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int LEN_W = LEN_W_DEF
);

  logic             in_valid;
  logic             match;
  logic             clear;
  logic [CNT_W-1:0] id_count;
  logic [LEN_W-1:0] run_len;
  logic [LEN_W-1:0] last_len;
  logic [LEN_W-1:0] max_len;
  logic             done;
  logic             ovf;

  // Sample source side: drives samples and clear, observes statistics
  modport master (
    output in_valid, match, clear,
    input  id_count, run_len, last_len, max_len, done, ovf
  );

  // Statistics block side
  modport slave (
    input  in_valid, match, clear,
    output id_count, run_len, last_len, max_len, done, ovf
  );

endinterface

// File: rtl/id_stat_cnt.sv
// rtl/id_stat_cnt.sv - increment/clear counter with wrap or saturate (ID_STAT_SAT_EN) and overflow strobe
module id_stat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         ovf
);

  logic at_max;

  assign at_max = &q;

  // Overflow is an attempted increment from all-ones; clear wins over it
  assign ovf = inc & ~clr & at_max;

  // Counter register: clear has priority over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
`ifdef ID_STAT_SAT_EN
      if (!at_max) begin
        q <= q + W'(1);
      end
`else
      q <= q + W'(1);
`endif
    end
  end

endmodule

// File: rtl/id_stat.sv
// rtl/id_stat.sv - identifier token statistics; ID_STAT_SAT_EN selects saturating counters
module id_stat
  import id_stat_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic     clk,
  input  logic     rst_n,
  id_stat_if.slave bus
);

  state_t           state_q;
  state_t           state_d;
  logic             id_inc;
  logic             run_inc;
  logic             run_clr;
  logic             tok_done;
  logic             id_ovf;
  logic             run_ovf;
  logic [CNT_W-1:0] id_q;
  logic [LEN_W-1:0] run_q;
  logic [LEN_W-1:0] last_q;
  logic [LEN_W-1:0] max_q;
  logic             done_q;
  logic             ovf_q;

  // Next state and counter controls; clear discards any sample on the same edge
  always_comb begin
    state_d  = state_q;
    id_inc   = 1'b0;
    run_inc  = 1'b0;
    run_clr  = bus.clear;
    tok_done = 1'b0;
    if (bus.clear) begin
      state_d = IDLE;
    end else if (bus.in_valid) begin
      case (state_q)
        IDLE: begin
          if (bus.match) begin
            state_d = RUN;
            run_inc = 1'b1;
          end
        end
        RUN: begin
          if (bus.match) begin
            run_inc = 1'b1;
          end else begin
            state_d  = IDLE;
            id_inc   = 1'b1;
            run_clr  = 1'b1;
            tok_done = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  id_stat_cnt #(.W(CNT_W)) u_id_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.clear),
    .inc   (id_inc),
    .q     (id_q),
    .ovf   (id_ovf)
  );

  // run_len is zero whenever IDLE, so a plain increment starts a token at 1
  id_stat_cnt #(.W(LEN_W)) u_run_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (run_clr),
    .inc   (run_inc),
    .q     (run_q),
    .ovf   (run_ovf)
  );

  // Completed-token lengths, done pulse and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= '0;
      max_q  <= '0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (bus.clear) begin
      last_q <= '0;
      max_q  <= '0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      done_q <= tok_done;
      if (tok_done) begin
        last_q <= run_q;
        if (run_q > max_q) begin
          max_q <= run_q;
        end
      end
      if (id_ovf || run_ovf) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign bus.id_count = id_q;
  assign bus.run_len  = run_q;
  assign bus.last_len = last_q;
  assign bus.max_len  = max_q;
  assign bus.done     = done_q;
  assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_id_stat.sv
// tb/tb_id_stat.sv - scoreboard bench for id_stat (expectations follow ID_STAT_SAT_EN)
module tb_id_stat;
  import id_stat_pkg::*;

  localparam int CNT_W = CNT_W_DEF;
  localparam int LEN_W = LEN_W_DEF;

  typedef struct packed {
    logic [CNT_W-1:0] id;
    logic [LEN_W-1:0] run;
    logic [LEN_W-1:0] last;
    logic [LEN_W-1:0] mx;
    logic             done;
    logic             ovf;
  } obs_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  id_stat_if #(.CNT_W(CNT_W), .LEN_W(LEN_W)) bus ();

  id_stat #(.CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  obs_t exp_q[$];
  int   done_seen;

  int   m_busy, m_id, m_run, m_last, m_max, m_done, m_ovf;

  task automatic bump(inout int x, input int w);
    int top;
    top = (1 << w) - 1;
    if (x == top) begin
      m_ovf = 1;
`ifndef ID_STAT_SAT_EN
      x = 0;
`endif
    end else begin
      x = x + 1;
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_id = 0; m_run = 0; m_last = 0; m_max = 0; m_done = 0; m_ovf = 0;
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.id   = CNT_W'(m_id);
    o.run  = LEN_W'(m_run);
    o.last = LEN_W'(m_last);
    o.mx   = LEN_W'(m_max);
    o.done = (m_done != 0);
    o.ovf  = (m_ovf != 0);
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.id   = bus.id_count;
    o.run  = bus.run_len;
    o.last = bus.last_len;
    o.mx   = bus.max_len;
    o.done = bus.done;
    o.ovf  = bus.ovf;
    return o;
  endfunction

  // Drive one sample, advance the model, optionally push its expectation
  task automatic drive(input logic v, input logic m, input logic c, input logic push);
    bus.in_valid = v;
    bus.match    = m;
    bus.clear    = c;
    m_done = 0;
    if (c) begin
      model_reset();
    end else if (v) begin
      if (m_busy == 0) begin
        if (m) begin
          m_busy = 1;
          bump(m_run, LEN_W);
        end
      end else if (m) begin
        bump(m_run, LEN_W);
      end else begin
        bump(m_id, CNT_W);
        m_last = m_run;
        if (m_run > m_max) m_max = m_run;
        m_run  = 0;
        m_busy = 0;
        m_done = 1;
      end
    end
    if (push) exp_q.push_back(model_obs());
    @(posedge clk);
    #1;
    if (bus.done === 1'b1) done_seen++;
  endtask

  task automatic test_reset();
    obs_t o;
    bus.in_valid = 1'b0; bus.match = 1'b0; bus.clear = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #22;
    o = dut_obs();
    checks++;
    if (o !== '0) begin errors++; $display("FAIL reset_state: got %h expected 0", o); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    obs_t e, o;
    done_seen = 0;
    drive(1, 0, 0, 0);
    drive(1, 1, 0, 0);
    drive(1, 1, 0, 0);
    drive(1, 1, 0, 0);
    drive(1, 0, 0, 1);
    e = exp_q.pop_front(); o = dut_obs();
    checks++;
    if (o !== e) begin errors++; $display("FAIL basic_outputs: got %h expected %h", o, e); end
    checks++;
    if (bus.id_count !== CNT_W'(1) || bus.last_len !== LEN_W'(3) || bus.max_len !== LEN_W'(3) ||
        bus.run_len !== '0 || bus.done !== 1'b1) begin
      errors++; $display("FAIL basic_values: got %h expected id=1 last=3 max=3 run=0 done=1", o);
    end
    drive(0, 1, 0, 1);
    e = exp_q.pop_front(); o = dut_obs();
    checks++;
    if (o !== e) begin errors++; $display("FAIL basic_after: got %h expected %h", o, e); end
    checks++;
    if (done_seen !== 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", done_seen); end
  endtask

  task automatic test_lengths();
    obs_t e, o;
    int lens[3] = '{2, 5, 1};
    drive(0, 0, 1, 0);
    foreach (lens[k]) begin
      for (int i = 0; i < lens[k]; i++) drive(1, 1, 0, 0);
      drive(1, 0, 0, (k == 2));
    end
    e = exp_q.pop_front(); o = dut_obs();
    checks++;
    if (o !== e) begin errors++; $display("FAIL lengths_outputs: got %h expected %h", o, e); end
    checks++;
    if (bus.id_count !== CNT_W'(3) || bus.last_len !== LEN_W'(1) || bus.max_len !== LEN_W'(5)) begin
      errors++; $display("FAIL lengths_values: got %h expected id=3 last=1 max=5", o);
    end
  endtask

  task automatic test_gap();
    obs_t e, o;
    done_seen = 0;
    drive(1, 1, 0, 0);
    drive(1, 1, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, i[0], 0, (i == 3));
    e = exp_q.pop_front(); o = dut_obs();
    checks++;
    if (o !== e) begin errors++; $display("FAIL gap_hold: got %h expected %h", o, e); end
    drive(1, 1, 0, 0);
    drive(1, 0, 0, 1);
    e = exp_q.pop_front(); o = dut_obs();
    checks++;
    if (o !== e) begin errors++; $display("FAIL gap_outputs: got %h expected %h", o, e); end
    checks++;
    if (bus.last_len !== LEN_W'(3) || done_seen !== 1) begin
      errors++; $display("FAIL gap_values: got last=%0d done_count=%0d expected last=3 done_count=1",
                         bus.last_len, done_seen);
    end
  endtask

  task automatic test_clear();
    obs_t e, o;
    done_seen = 0;
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 0);
    checks++;
    if (bus.run_len !== LEN_W'(4)) begin errors++; $display("FAIL clear_pre_run: got %0d expected 4", bus.run_len); end
    drive(1, 1, 1, 1);
    e = exp_q.pop_front(); o = dut_obs();
    checks++;
    if (o !== e || o !== '0) begin errors++; $display("FAIL clear_outputs: got %h expected %h", o, e); end
    drive(1, 0, 0, 1);
    e = exp_q.pop_front(); o = dut_obs();
    checks++;
    if (o !== e || done_seen !== 0) begin
      errors++; $display("FAIL clear_idle: got %h done_count=%0d expected %h done_count=0", o, done_seen, e);
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, o;
    done_seen = 0;
    drive(1, 1, 0, 0);
    drive(1, 0, 0, 0);
    drive(1, 1, 0, 0);
    drive(1, 1, 0, 0);
    drive(1, 0, 0, 1);
    e = exp_q.pop_front(); o = dut_obs();
    checks++;
    if (o !== e || done_seen !== 2) begin
      errors++; $display("FAIL b2b_outputs: got %h done_count=%0d expected %h done_count=2", o, done_seen, e);
    end
  endtask

  task automatic test_count_ovf();
    obs_t e, o;
    logic [CNT_W-1:0] want;
`ifdef ID_STAT_SAT_EN
    want = '1;
`else
    want = '0;
`endif
    drive(0, 0, 1, 0);
    for (int i = 0; i < 256; i++) begin
      drive(1, 1, 0, 0);
      drive(1, 0, 0, (i == 255));
      if (i == 254) begin
        checks++;
        if (bus.ovf !== 1'b0 || bus.id_count !== 8'd255) begin
          errors++; $display("FAIL cnt_pre_ovf: got id=%0d ovf=%b expected id=255 ovf=0", bus.id_count, bus.ovf);
        end
      end
    end
    e = exp_q.pop_front(); o = dut_obs();
    checks++;
    if (o !== e) begin errors++; $display("FAIL cnt_ovf_outputs: got %h expected %h", o, e); end
    checks++;
    if (bus.id_count !== want || bus.ovf !== 1'b1) begin
      errors++; $display("FAIL cnt_ovf_values: got id=%0d ovf=%b expected id=%0d ovf=1", bus.id_count, bus.ovf, want);
    end
  endtask

  task automatic test_run_ovf();
    obs_t e, o;
    drive(0, 0, 1, 0);
    for (int i = 0; i < 64; i++) drive(1, 1, 0, (i == 63));
    e = exp_q.pop_front(); o = dut_obs();
    checks++;
    if (o !== e) begin errors++; $display("FAIL run_ovf_outputs: got %h expected %h", o, e); end
    drive(1, 0, 0, 1);
    e = exp_q.pop_front(); o = dut_obs();
    checks++;
    if (o !== e) begin errors++; $display("FAIL run_ovf_close: got %h expected %h", o, e); end
  endtask

  task automatic test_async_reset();
    obs_t e, o;
    drive(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) drive(1, 1, 0, 0);
    bus.in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    o = dut_obs();
    checks++;
    if (o !== '0) begin errors++; $display("FAIL async_reset_now: got %h expected 0", o); end
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    done_seen = 0;
    drive(1, 0, 0, 1);
    e = exp_q.pop_front(); o = dut_obs();
    checks++;
    if (o !== e || done_seen !== 0) begin
      errors++; $display("FAIL async_reset_nodone: got %h done_count=%0d expected %h done_count=0", o, done_seen, e);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lengths();
    test_gap();
    test_clear();
    test_back_to_back();
    test_count_ovf();
    test_run_ovf();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

endmodule

// File: doc/id_stat.md
ID_STAT -- requirements
Module: id_stat

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the completed-identifier counter.
REQ-002 SHALL have parameter LEN_W, default 6, width of the run-length and length registers.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid  input  1  match sample is valid this cycle.
REQ-006 SHALL have port match  input  1  recogniser output (1 = stream currently forms letters-then-digits identifier).
REQ-007 SHALL have port clear  input  1  synchronous clear of all statistics.
REQ-008 SHALL have port id_count  output  CNT_W  number of completed identifier tokens.
REQ-009 SHALL have port run_len  output  LEN_W  consecutive valid match=1 samples in the current token.
REQ-010 SHALL have port last_len  output  LEN_W  length of the most recently completed token.
REQ-011 SHALL have port max_len  output  LEN_W  longest completed token since reset/clear.
REQ-012 SHALL have port done  output  1  one-cycle pulse when a token completes.
REQ-013 SHALL have port ovf  output  1  sticky overflow flag.

Function
REQ-014 SHALL implement a two-state FSM: IDLE (no token in progress), RUN (token in progress).
REQ-015 With in_valid=0, SHALL hold state and all registers; done SHALL be 0.
REQ-016 IDLE, in_valid=1, match=1 -> RUN, run_len<=1.
REQ-017 IDLE, in_valid=1, match=0 -> stay IDLE, no register change.
REQ-018 RUN, in_valid=1, match=1 -> stay RUN, run_len<=run_len+1.
REQ-019 RUN, in_valid=1, match=0 -> IDLE; id_count+1; last_len<=run_len; max_len<=run_len if run_len>max_len; run_len<=0; done=1 for exactly that following cycle.
REQ-020 All outputs SHALL be registered; effect of a sample visible one cycle after the edge that samples it.
REQ-021 clear=1 SHALL override all FSM activity that edge: state IDLE, all counts/lengths 0, done 0, ovf 0; a simultaneous valid match sample is discarded.
REQ-022 A token still in RUN is never counted until a valid match=0 sample arrives.
REQ-023 Overflow of id_count or run_len SHALL follow the Configuration rule; ovf SHALL set on any overflow and stay set until clear or reset.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, id_count, run_len, last_len, max_len 0, done 0, ovf 0, independent of clk.
REQ-025 Reset asserted mid-token SHALL discard the token without counting it or pulsing done.
REQ-026 Release of rst_n SHALL take effect at the first rising clk edge with rst_n high.

Configuration
REQ-027 Macro ID_STAT_SAT_EN defined: id_count and run_len SHALL saturate at all-ones and hold; ovf sets on the first attempted increment past all-ones.
REQ-028 Macro ID_STAT_SAT_EN undefined: id_count and run_len SHALL wrap modulo 2^width; ovf sets on the wrap to 0.

Structure
REQ-029 Package id_stat_pkg SHALL hold the state enumeration (IDLE, RUN) and default width constants.
REQ-030 Sub-module id_stat_cnt SHALL implement one increment/clear counter with wrap-or-saturate behaviour and overflow strobe, instantiated for id_count and run_len.

Verification
REQ-031 Reset, then valid match 0,1,1,1,0 -> done pulse once; id_count=1, last_len=3, max_len=3, run_len=0.
REQ-032 Tokens of length 2 then 5 then 1 -> id_count=3, last_len=1, max_len=5.
REQ-033 Valid match 1,1, in_valid=0 for 4 cycles, then valid 1,0 -> last_len=3, single done pulse.
REQ-034 Mid-token (run_len=4) clear=1 with match=1 -> next cycle all outputs 0, state IDLE, no done.
REQ-035 CNT_W=8, 256 tokens -> with ID_STAT_SAT_EN id_count=255, ovf=1; without, id_count=0, ovf=1.
REQ-036 rst_n pulsed low between clock edges during RUN -> outputs 0 immediately, following match=0 sample gives no done.
